// File: rtl/taylor_ln_pkg.sv
// Shared constants, state/op encodings and the float rounding helper for the
// ln(x) Taylor sequencer about a = 0.375.
package taylor_ln_pkg;

    localparam logic [31:0] C0375   = 32'h3EC00000;
    localparam logic [31:0] NEG0375 = 32'hBEC00000;
    localparam logic [31:0] LN0375  = 32'hBF7B17A0;

    typedef enum logic [2:0] {
        S_IDLE, S_SUB, S_NORM, S_ACC1, S_POW, S_TERM, S_ACC, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_SUB, OP_NORM, OP_ACC1, OP_POW, OP_TERM, OP_ACC
    } op_t;

    // Float value of the series divisor k (2..16).
    function automatic logic [31:0] kf(input logic [4:0] k);
        logic [31:0] r;
        case (k)
            5'd2:    r = 32'h40000000;
            5'd3:    r = 32'h40400000;
            5'd4:    r = 32'h40800000;
            5'd5:    r = 32'h40A00000;
            5'd6:    r = 32'h40C00000;
            5'd7:    r = 32'h40E00000;
            5'd8:    r = 32'h41000000;
            5'd9:    r = 32'h41100000;
            5'd10:   r = 32'h41200000;
            5'd11:   r = 32'h41300000;
            5'd12:   r = 32'h41400000;
            5'd13:   r = 32'h41500000;
            5'd14:   r = 32'h41600000;
            5'd15:   r = 32'h41700000;
            5'd16:   r = 32'h41800000;
            default: r = 32'h3F800000;
        endcase
        return r;
    endfunction

    // m = {hidden, 23 frac, guard, round, sticky}; round to nearest even.
    // Subnormal results flush to zero, overflow saturates to infinity.
    function automatic logic [31:0] fp_round_pack(input logic s,
                                                  input logic signed [9:0] e,
                                                  input logic [26:0] m);
        logic [24:0]       mr;
        logic signed [9:0] er;
        logic              inc;
        logic [31:0]       r;
        inc = m[2] & (m[3] | m[1] | m[0]);
        mr  = {1'b0, m[26:3]} + {24'd0, inc};
        er  = e;
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 10'sd1;
        end
        if (m == 27'd0 || er <= 10'sd0)
            r = {s, 31'd0};
        else if (er >= 10'sd255)
            r = {s, 8'hFF, 23'd0};
        else
            r = {s, er[7:0], mr[22:0]};
        return r;
    endfunction

endpackage

// File: rtl/taylor_ln_dp.sv
// Shared float datapath: one adder, one multiplier and one divider behind
// operand muxes selected by the sequencer's op code.
module taylor_ln_dp
    import taylor_ln_pkg::*;
(
    input  op_t         op,
    input  logic [4:0]  k,
    input  logic [31:0] x_r,
    input  logic [31:0] d,
    input  logic [31:0] t,
    input  logic [31:0] p,
    input  logic [31:0] q,
    input  logic [31:0] acc,
    output logic [31:0] res
);

    function automatic logic [31:0] fp_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sub);
        logic              s_l, s_s;
        logic [7:0]        e_l, e_s, diff;
        logic [26:0]       m_a, m_b, m_l, m_s, sh, m;
        logic [27:0]       sum;
        logic              sticky;
        logic signed [9:0] er;
        logic [4:0]        lz;
        logic [31:0]       r;
        m_a = (a[30:23] == 8'd0) ? 27'd0 : {1'b1, a[22:0], 3'b000};
        m_b = (b[30:23] == 8'd0) ? 27'd0 : {1'b1, b[22:0], 3'b000};
        if (a[30:0] >= b[30:0]) begin
            s_l = a[31];       e_l = a[30:23]; m_l = m_a;
            s_s = b[31] ^ sub; e_s = b[30:23]; m_s = m_b;
        end else begin
            s_l = b[31] ^ sub; e_l = b[30:23]; m_l = m_b;
            s_s = a[31];       e_s = a[30:23]; m_s = m_a;
        end
        diff = e_l - e_s;
        if (diff >= 8'd27) begin
            sh     = 27'd0;
            sticky = |m_s;
        end else begin
            sh     = m_s >> diff;
            sticky = |(m_s & ~(27'h7FFFFFF << diff));
        end
        sh[0] = sh[0] | sticky;
        sum = (s_l ^ s_s) ? ({1'b0, m_l} - {1'b0, sh}) : ({1'b0, m_l} + {1'b0, sh});
        er  = $signed({2'b00, e_l});
        lz  = 5'd0;
        m   = 27'd0;
        if (sum == 28'd0) begin
            r = 32'd0;
        end else begin
            if (sum[27]) begin
                m  = {sum[27:2], sum[1] | sum[0]};
                er = er + 10'sd1;
            end else begin
                for (int i = 0; i < 27; i++)
                    if (sum[i]) lz = 5'(26 - i);
                m  = sum[26:0] << lz;
                er = er - $signed({5'd0, lz});
            end
            r = fp_round_pack(s_l, er, m);
        end
        return r;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [47:0]       prod;
        logic [26:0]       m;
        logic signed [9:0] er;
        logic [31:0]       r;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            r = {s, 31'd0};
        end else begin
            prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            er   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            if (prod[47]) begin
                m  = {prod[47:22], |prod[21:0]};
                er = er + 10'sd1;
            end else begin
                m  = {prod[46:21], |prod[20:0]};
            end
            r = fp_round_pack(s, er, m);
        end
        return r;
    endfunction

    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [49:0]       num, den, quo, rem;
        logic [26:0]       m;
        logic signed [9:0] er;
        logic [31:0]       r;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0) begin
            r = {s, 31'd0};
        end else if (b[30:23] == 8'd0) begin
            r = {s, 8'hFF, 23'd0};
        end else begin
            // Quotient of the two 1.f mantissas lands in (2^25, 2^27).
            num = {1'b1, a[22:0], 26'd0};
            den = {26'd0, 1'b1, b[22:0]};
            quo = num / den;
            rem = num % den;
            er  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
            if (quo[26]) begin
                m = {quo[26:1], quo[0] | (rem != 50'd0)};
            end else begin
                m  = {quo[25:0], rem != 50'd0};
                er = er - 10'sd1;
            end
            r = fp_round_pack(s, er, m);
        end
        return r;
    endfunction

    logic [31:0] add_a, add_b, mul_a, mul_b, div_a, div_b;
    logic [31:0] add_y, mul_y, div_y;
    logic        add_sub;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        mul_a   = '0;
        mul_b   = '0;
        div_a   = '0;
        div_b   = C0375;
        case (op)
            OP_SUB:  begin add_a = x_r;    add_b = NEG0375; end
            OP_NORM: begin div_a = d;      div_b = C0375;   end
            OP_ACC1: begin add_a = LN0375; add_b = t;       end
            OP_POW:  begin mul_a = p;      mul_b = t;       end
            OP_TERM: begin div_a = p;      div_b = kf(k);   end
            OP_ACC:  begin add_a = acc;    add_b = q;  add_sub = ~k[0]; end
            default: ;
        endcase
    end

    assign add_y = fp_add(add_a, add_b, add_sub);
    assign mul_y = fp_mul(mul_a, mul_b);
    assign div_y = fp_div(div_a, div_b);

    always_comb begin
        res = add_y;
        case (op)
            OP_NORM, OP_TERM: res = div_y;
            OP_POW:           res = mul_y;
            default:          res = add_y;
        endcase
    end

endmodule

// File: rtl/taylor_ln_seq.sv
// Iterative ln(x) Taylor sequencer about 0.375: FSM, term counter and the
// series registers around one shared ADD/MUL/DIV datapath.
//
// state | meaning
// IDLE  | waiting for start; latches x
// SUB   | d = x - 0.375 (|x| == 0.375 goes straight to DONE from here)
// NORM  | t = p = d / 0.375
// ACC1  | acc = ln(0.375) + t, k = 2
// POW   | p = p * t
// TERM  | q = p / k
// ACC   | acc = acc -/+ q (even k subtracts); last term loads out
// DONE  | done pulse, out valid
module taylor_ln_seq
    import taylor_ln_pkg::*;
#(
    parameter int N_TERMS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    localparam logic [4:0] K_LAST = 5'(N_TERMS);

    state_t      state;
    op_t         op;
    logic [4:0]  k;
    logic [31:0] x_r, d, t, p, q, acc, res;

    always_comb begin
        op = OP_NONE;
        case (state)
            S_SUB:   op = OP_SUB;
            S_NORM:  op = OP_NORM;
            S_ACC1:  op = OP_ACC1;
            S_POW:   op = OP_POW;
            S_TERM:  op = OP_TERM;
            S_ACC:   op = OP_ACC;
            default: op = OP_NONE;
        endcase
    end

    taylor_ln_dp u_dp (
        .op  (op),
        .k   (k),
        .x_r (x_r),
        .d   (d),
        .t   (t),
        .p   (p),
        .q   (q),
        .acc (acc),
        .res (res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            k     <= '0;
            x_r   <= '0;
            d     <= '0;
            t     <= '0;
            p     <= '0;
            q     <= '0;
            acc   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_r   <= in;
                        busy  <= 1'b1;
                        state <= S_SUB;
                    end
                end
                S_SUB: begin
                    // The bypass spends its one busy cycle here, giving a 2-cycle latency.
                    if (x_r[30:0] == C0375[30:0]) begin
                        out   <= LN0375;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        d     <= res;
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    t     <= res;
                    p     <= res;
                    state <= S_ACC1;
                end
                S_ACC1: begin
                    acc   <= res;
                    k     <= 5'd2;
                    state <= S_POW;
                end
                S_POW: begin
                    p     <= res;
                    state <= S_TERM;
                end
                S_TERM: begin
                    q     <= res;
                    state <= S_ACC;
                end
                S_ACC: begin
                    acc <= res;
                    if (k == K_LAST) begin
                        out   <= res;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        k     <= k + 5'd1;
                        state <= S_POW;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_taylor_ln_seq.sv
// Bench for taylor_ln_seq: a cycle-level reference (latency and series sum in
// real arithmetic) checked every cycle, plus directed literal expectations.
module tb_taylor_ln_seq;

    localparam int N = 10;
    localparam int LAT_FULL = 3 + 3 * (N - 1) + 1;
    localparam int LAT_BYP = 2;

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [31:0] in_v, out_v;

    int tests = 0;
    int fails = 0;

    taylor_ln_seq #(.N_TERMS(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_v),
        .busy  (busy),
        .done  (done),
        .out   (out_v)
    );

    always #5 clk = ~clk;

    function automatic real absr(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real bits2real(input logic [31:0] b);
        real r;
        int  ex;
        if (b[30:23] == 8'd0) return 0.0;
        r  = 1.0 + real'(b[22:0]) / 8388608.0;
        ex = int'(b[30:23]) - 127;
        while (ex > 0) begin r = r * 2.0; ex--; end
        while (ex < 0) begin r = r / 2.0; ex++; end
        return b[31] ? -r : r;
    endfunction

    // Truncated series ln(0.375) + sum (-1)^(k+1) t^k / k.
    function automatic real model_ln(input real x);
        real l0, t, pw, s;
        l0 = bits2real(32'hBF7B17A0);
        if (absr(x) == 0.375) return l0;
        t  = (x - 0.375) / 0.375;
        pw = t;
        s  = l0;
        for (int kk = 1; kk <= N; kk++) begin
            if (kk % 2 == 1) s = s + pw / kk;
            else             s = s - pw / kk;
            pw = pw * t;
        end
        return s;
    endfunction

    task automatic chk_bits(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_near(input string name, input real got, input real exp);
        tests++;
        if (!(absr(got - exp) <= 1.0e-5)) begin
            fails++;
            $display("FAIL %s: got %f expected %f at %0t", name, got, exp, $time);
        end
    endtask

    // Reference sequencer: tracks acceptance, latency and expected result.
    bit  m_init = 0, m_active = 0, m_zero = 1, m_have = 0;
    int  m_cyc = 0, m_lat = 0;
    real m_pend = 0.0, m_exp = 0.0;

    always @(posedge clk) begin
        real x;
        if (rst) begin
            m_init   = 1;
            m_active = 0;
            m_zero   = 1;
            m_have   = 0;
        end else if (m_active) begin
            if (m_cyc == m_lat) begin
                m_active = 0;
            end else begin
                m_cyc++;
                if (m_cyc == m_lat) begin
                    m_exp  = m_pend;
                    m_have = 1;
                    m_zero = 0;
                end
            end
        end else if (start) begin
            x        = bits2real(in_v);
            m_active = 1;
            m_cyc    = 1;
            m_lat    = (absr(x) == 0.375) ? LAT_BYP : LAT_FULL;
            m_pend   = model_ln(x);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk_bits("busy", {31'd0, busy}, {31'd0, m_active});
            chk_bits("done", {31'd0, done}, {31'd0, (m_active && m_cyc == m_lat)});
            if (m_zero)
                chk_bits("out_zero", out_v, 32'd0);
            else if (m_have)
                chk_near("out_model", bits2real(out_v), m_exp);
        end
    end

    task automatic run_op(input string name, input logic [31:0] x, input int exp_lat,
                          input int mid_at, input logic [31:0] mid_x,
                          output logic [31:0] res);
        int n, bcnt;
        @(negedge clk);
        start = 1'b1;
        in_v  = x;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        bcnt  = busy ? 1 : 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == mid_at) begin
                start = 1'b1;
                in_v  = mid_x;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (busy === 1'b1) bcnt++;
        end
        start = 1'b0;
        chk_bits({name, "_latency"}, (done === 1'b1) ? n : -1, exp_lat);
        chk_bits({name, "_busy_cycles"}, bcnt, exp_lat);
        res = out_v;
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    initial begin
        logic [31:0] r;
        int          cnt;
        rst   = 1'b1;
        start = 1'b0;
        in_v  = 32'd0;

        chk_near("model_ln_0p5", model_ln(0.5), -0.693147);
        chk_near("model_ln_0p25", model_ln(0.25), -1.386294);
        chk_near("model_ln_0p375", model_ln(0.375), -0.980829);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_bits("reset_out", out_v, 32'd0);
        chk_bits("reset_busy", {31'd0, busy}, 32'd0);
        chk_bits("reset_done", {31'd0, done}, 32'd0);

        run_op("bypass_pos", 32'h3EC00000, LAT_BYP, 0, 32'd0, r);
        chk_bits("bypass_pos_out", r, 32'hBF7B17A0);
        repeat (2) @(negedge clk);

        run_op("bypass_neg", 32'hBEC00000, LAT_BYP, 0, 32'd0, r);
        chk_bits("bypass_neg_out", r, 32'hBF7B17A0);
        repeat (2) @(negedge clk);

        run_op("x_0p5", 32'h3F000000, LAT_FULL, 0, 32'd0, r);
        chk_near("x_0p5_out", bits2real(r), -0.693147);
        repeat (3) @(negedge clk);
        chk_near("x_0p5_held", bits2real(out_v), -0.693147);

        run_op("x_0p25", 32'h3E800000, LAT_FULL, 0, 32'd0, r);
        chk_near("x_0p25_out", bits2real(r), -1.386294);
        repeat (2) @(negedge clk);

        run_op("x_0p6", 32'h3F19999A, LAT_FULL, 0, 32'd0, r);
        chk_near("x_0p6_out", bits2real(r), model_ln(bits2real(32'h3F19999A)));
        run_op("x_0p1", 32'h3DCCCCCD, LAT_FULL, 0, 32'd0, r);
        chk_near("x_0p1_out", bits2real(r), model_ln(bits2real(32'h3DCCCCCD)));
        run_op("x_0p7", 32'h3F333333, LAT_FULL, 0, 32'd0, r);
        chk_near("x_0p7_out", bits2real(r), model_ln(bits2real(32'h3F333333)));
        repeat (2) @(negedge clk);

        // start pulsed mid-run with a different operand must be ignored
        run_op("mid_start", 32'h3F000000, LAT_FULL, 8, 32'h3E800000, r);
        chk_near("mid_start_out", bits2real(r), -0.693147);
        count_done(40, cnt);
        chk_bits("mid_start_extra_done", cnt, 0);

        // reset in cycle 10 of a run aborts it
        @(negedge clk);
        start = 1'b1;
        in_v  = 32'h3E800000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_bits("abort_busy", {31'd0, busy}, 32'd0);
        chk_bits("abort_done", {31'd0, done}, 32'd0);
        chk_bits("abort_out", out_v, 32'd0);
        count_done(40, cnt);
        chk_bits("abort_no_done", cnt, 0);

        run_op("after_abort", 32'h3F000000, LAT_FULL, 0, 32'd0, r);
        chk_near("after_abort_out", bits2real(r), -0.693147);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
